key_event_conditioner: RTL
==========================

Name: key_event_conditioner

Overview:
- Front-end for the four user push-buttons; sits directly upstream of the mode blocks (watch, watch-set, alarm, stopwatch) and replaces the per-switch debouncer outputs.
- Synchronises and debounces each raw switch, then emits clean per-key events: press pulse, release pulse, long-press level and auto-repeat pulses.
- Mode blocks use the repeat pulses to fast-advance digits while a key is held.

Parameters:
- NKEY, 4, number of independent key channels.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- DEB_CYCLES, 500000, clock cycles the synchronised input must differ from the committed state before a change is accepted (10 ms at 50 MHz).
- LONG_CYCLES, 25000000, hold time after a committed press before long-press is declared (0.5 s).
- REP_CYCLES, 5000000, auto-repeat period once long-press is active (0.1 s).
- CNT_W, 25, counter width; must hold max(DEB_CYCLES, LONG_CYCLES, REP_CYCLES) - 1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- sw_raw, input, NKEY, raw switch pins; asynchronous to clk.
- key_level, output, NKEY, debounced pressed state; 1 = pressed.
- key_press, output, NKEY, one-cycle pulse on a committed press.
- key_release, output, NKEY, one-cycle pulse on a committed release.
- key_long, output, NKEY, high while the key is held past LONG_CYCLES.
- key_repeat, output, NKEY, one-cycle pulse at long-press entry and every REP_CYCLES thereafter.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - Synchroniser flops load the released pin level: 1 if ACTIVE_LOW, else 0.
  - All counters 0; every channel in IDLE.
- Synchroniser: 2-FF per bit. Pin is normalised so that 1 = pressed after stage 2 (inverted when ACTIVE_LOW).
- Channels are fully independent. Simultaneous activity on several keys produces simultaneous, unrelated pulses.
- Debounce, per channel:
  - deb_cnt increments each cycle that the synchronised value differs from key_level.
  - deb_cnt clears to 0 on any cycle the two agree; a glitch restarts the count.
  - On the cycle deb_cnt == DEB_CYCLES-1 with mismatch still present: key_level toggles, deb_cnt clears, and key_press (0->1) or key_release (1->0) pulses in the same cycle.
  - Latency: pin stable pressed from edge N -> key_level and key_press high at edge N+2+DEB_CYCLES.
- Hold FSM, per channel:
  - IDLE: key_level=0, hold_cnt=0. A committed press moves to HELD.
  - HELD: hold_cnt increments each cycle. At hold_cnt == LONG_CYCLES-1: key_long<=1, one key_repeat pulse, hold_cnt<=0, go to REPEAT.
  - REPEAT: hold_cnt increments. At REP_CYCLES-1: key_repeat pulse, hold_cnt<=0, stay in REPEAT.
  - Committed release from HELD or REPEAT: key_long<=0, hold_cnt<=0, go to IDLE. No key_repeat is issued in the release cycle, even if hold_cnt expires in that same cycle (release wins).
- Release bounce after a press is absorbed by the debouncer; key_level never toggles faster than once per DEB_CYCLES.
- key_press and key_repeat never assert in the same cycle for the same key.
- Counters saturate-free: each counter is always cleared before reaching 2^CNT_W.
- Reset asserted mid-hold: immediate return to reset values. No release pulse is issued on deassertion.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- Defined: HELD/REPEAT behaviour exactly as above.
- Undefined:
  - No REPEAT state and no REP_CYCLES counter logic.
  - key_repeat tied to 0.
  - key_long still asserts at LONG_CYCLES and holds until release.
  - hold_cnt stops counting once key_long is set.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, REP_CYCLES=8, ACTIVE_LOW=1):
- Reset release, sw_raw=4'b1111 for 50 cycles -> all outputs stay 0.
- sw_raw[0] driven 0 at edge 10 and held -> key_level[0]=1 and key_press[0] single pulse at edge 16; other bits unaffected.
- sw_raw[1] low for 3 cycles then high, repeated 5 times -> no key_press[1], key_level[1] stays 0.
- sw_raw[2] held low 60 cycles after commit -> key_long[2]=1 and key_repeat[2] at commit+20, then repeats at +28, +36, +44, +52.
- Then sw_raw[2] released -> key_release[2] pulse exactly once, key_long[2]=0, no further repeats.
- Keys 0 and 3 pressed on the same edge; rst pulsed low mid-hold -> presses pulse together; during reset all outputs 0 at once, no release pulse afterwards.
- Build without KEY_AUTOREPEAT_EN, hold key 0 for 60 cycles -> key_long[0] at commit+20, key_repeat stays 0.

Source files
------------

// File: rtl/key_event_conditioner.sv
// Synchronises, debounces and classifies the user push-buttons into press, release, long-press and repeat events.
// Define KEY_AUTOREPEAT_EN to build the auto-repeat path; without it key_repeat is tied low.
module key_event_conditioner #(
  parameter int NKEY        = 4,
  parameter int ACTIVE_LOW  = 1,
  parameter int DEB_CYCLES  = 500000,
  parameter int LONG_CYCLES = 25000000,
  parameter int REP_CYCLES  = 5000000,
  parameter int CNT_W       = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] sw_raw,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NKEY-1:0] key_long,
  output logic [NKEY-1:0] key_repeat
);

  // Hold FSM, one instance per key:
  //   state    | meaning
  //   S_IDLE   | key released, hold counter parked at 0
  //   S_HELD   | committed press, timing towards long-press
  //   S_REPEAT | long-press active, counting repeat periods (autorepeat build)
  //   S_LONG   | long-press active, counter frozen (no autorepeat)
`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYCLES - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;
`endif

  localparam logic             REL_PIN   = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [NKEY-1:0] sync1;
  logic [NKEY-1:0] sync2;
  logic [NKEY-1:0] pressed_s;

  // Synchroniser parks at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= {NKEY{REL_PIN}};
      sync2 <= {NKEY{REL_PIN}};
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  assign pressed_s = REL_PIN ? ~sync2 : sync2;

  for (genvar k = 0; k < NKEY; k++) begin : g_ch
    logic [CNT_W-1:0] deb_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             mismatch;
    logic             commit;
    logic             press_c;
    logic             release_c;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             long_q;
    logic             long_d;

    assign mismatch  = pressed_s[k] != level_q;
    assign commit    = mismatch && (deb_cnt == DEB_LAST);
    assign press_c   = commit && !level_q;
    assign release_c = commit && level_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deb_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_c;
        release_q <= release_c;
        if (commit) begin
          level_q <= ~level_q;
          deb_cnt <= '0;
        end else if (mismatch) begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end else begin
          deb_cnt <= '0;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:   if (press_c) state_d = S_HELD;
        S_HELD: begin
          if (release_c)
            state_d = S_IDLE;
          else if (hold_q == LONG_LAST)
`ifdef KEY_AUTOREPEAT_EN
            state_d = S_REPEAT;
`else
            state_d = S_LONG;
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        S_REPEAT: if (release_c) state_d = S_IDLE;
`else
        S_LONG:   if (release_c) state_d = S_IDLE;
`endif
        default:  state_d = S_IDLE;
      endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    logic rep_q;
    logic rep_d;
`endif

    // Release always wins over a counter expiring in the same cycle.
    always_comb begin
      hold_d = '0;
      long_d = long_q;
`ifdef KEY_AUTOREPEAT_EN
      rep_d  = 1'b0;
`endif
      case (state_q)
        S_IDLE: long_d = 1'b0;
        S_HELD: begin
          if (release_c) begin
            long_d = 1'b0;
          end else if (hold_q == LONG_LAST) begin
            long_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rep_d  = 1'b1;
`endif
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
`ifdef KEY_AUTOREPEAT_EN
        S_REPEAT: begin
          if (release_c)
            long_d = 1'b0;
          else if (hold_q == REP_LAST)
            rep_d = 1'b1;
          else
            hold_d = hold_q + CNT_W'(1);
        end
`else
        S_LONG: if (release_c) long_d = 1'b0;
`endif
        default: long_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= S_IDLE;
        hold_q  <= '0;
        long_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        long_q  <= long_d;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= rep_d;
`endif
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;
`ifdef KEY_AUTOREPEAT_EN
    assign key_repeat[k]  = rep_q;
`endif
  end

`ifndef KEY_AUTOREPEAT_EN
  // REP_CYCLES stays on the interface so both builds share one instantiation.
  assign key_repeat = {NKEY{REP_CYCLES < 0}};
`endif

endmodule
